// File: rtl/byte_serializer.sv
// Framed serializer: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Define BYTE_SERIALIZER_PARITY_EN to insert the parity bit between data and stop.
module byte_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef BYTE_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BIT_W-1:0] bit_q;
  logic [DIV_W-1:0] div_q;
  logic             sout_q;
  logic             busy_q;
  logic             ready_q;
  logic             done_q;
  logic             div_wrap;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  assign div_wrap   = (div_q == DIV_LAST);
  assign din_ready  = ready_q;
  assign sout       = sout_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        div_q <= div_wrap ? '0 : div_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (din_valid && ready_q) begin
            shift_q <= din;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= START;
            sout_q  <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            par_q   <= ^din;
`endif
          end
        end
        START: begin
          if (div_wrap) begin
            state_q <= DATA;
            sout_q  <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        DATA: begin
          if (div_wrap) begin
            if (bit_q == BIT_LAST) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
              state_q <= PARITY;
              sout_q  <= par_q;
`else
              state_q <= STOP;
              sout_q  <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              sout_q  <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef BYTE_SERIALIZER_PARITY_EN
        PARITY: begin
          if (div_wrap) begin
            state_q <= STOP;
            sout_q  <= 1'b1;
          end
        end
`endif
        STOP: begin
          // Returning to IDLE re-opens the handshake in the same cycle frame_done is seen.
          if (div_wrap) begin
            state_q <= IDLE;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          sout_q  <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
